// File: rtl/crv32_soc.sv
// iCE40 SoC: picorv32 native bus shared with a debug master, word RAM and an 8N1 UART.
// With cpu_n_reset low the dbg_* nets own the bus; reads return data one cycle after the request.
module crv32_soc #(
  parameter int CLK_HZ    = 12_000_000,
  parameter int BAUD      = 115200,
  parameter int RAM_WORDS = 1024
) (
  input  logic CLK,
  input  logic RESET,
  input  logic PICO_UART1_RX,
  output logic PICO_UART1_TX
);
  localparam int DIV  = CLK_HZ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);
  localparam int AW   = $clog2(RAM_WORDS);
  localparam logic [31:0] A_DATA = 32'h0001_0010;
  localparam logic [31:0] A_STAT = 32'h0001_0014;

  // Fixed-name nets; benches override these with force.
  logic        cpu_n_reset;
  logic        dbg_mem_op;
  logic [3:0]  dbg_wren;
  logic [31:0] dbg_adr, dbg_do, dbg_di;
  assign cpu_n_reset = RESET;
  assign dbg_mem_op  = 1'b0;
  assign dbg_wren    = 4'h0;
  assign dbg_adr     = 32'h0;
  assign dbg_do      = 32'h0;

  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

`ifdef CRV32_WITH_PICORV32
  logic mem_instr, trap;
  picorv32 u_cpu (
    .clk(CLK), .resetn(cpu_n_reset), .trap(trap),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata)
  );
`else
  assign mem_valid = 1'b0;
  assign mem_addr  = 32'h0;
  assign mem_wdata = 32'h0;
  assign mem_wstrb = 4'h0;
`endif

  logic        mem_ready_q;
  logic        bus_valid;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_adr, bus_wdata, bus_rdata;

  // picorv32 keeps mem_valid up during the ready cycle; mask it so side effects fire once.
  assign bus_valid = cpu_n_reset ? (mem_valid & ~mem_ready_q) : dbg_mem_op;
  assign bus_wstrb = cpu_n_reset ? mem_wstrb : dbg_wren;
  assign bus_adr   = cpu_n_reset ? mem_addr  : dbg_adr;
  assign bus_wdata = cpu_n_reset ? mem_wdata : dbg_do;

  logic sel_ram, sel_data, sel_stat, bus_wr, bus_rd, wr_data, rd_data;
  assign sel_ram  = (bus_adr[31:AW+2] == '0);
  assign sel_data = (bus_adr == A_DATA);
  assign sel_stat = (bus_adr == A_STAT);
  assign bus_wr   = bus_valid & (|bus_wstrb);
  assign bus_rd   = bus_valid & ~(|bus_wstrb);
  assign wr_data  = bus_wr & sel_data;
  assign rd_data  = bus_rd & sel_data;

  // RAM: byte-strobed writes, registered read, contents not reset.
  logic [31:0] ram [RAM_WORDS];
  logic [31:0] ram_rd_q;
  logic [AW-1:0] ram_idx;
  assign ram_idx = bus_adr[AW+1:2];

  always_ff @(posedge CLK) begin
    if (bus_valid && sel_ram) begin
      for (int b = 0; b < 4; b++)
        if (bus_wstrb[b]) ram[ram_idx][8*b +: 8] <= bus_wdata[8*b +: 8];
      ram_rd_q <= ram[ram_idx];
    end
  end

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_st_e;

  // ---------------- TX ----------------
  uart_st_e       tx_st_q, tx_st_d;
  logic [CW-1:0]  tx_cnt_q, tx_cnt_d;
  logic [2:0]     tx_bit_q, tx_bit_d;
  logic [7:0]     tx_sh_q, tx_sh_d;
  logic           tx_q, tx_d;
  logic           tx_busy;
  assign tx_busy       = (tx_st_q != S_IDLE);
  assign PICO_UART1_TX = tx_q;

  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q + 1'b1;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    tx_d     = tx_q;
    case (tx_st_q)
      S_IDLE: begin
        tx_cnt_d = '0;
        if (wr_data) begin
          tx_st_d = S_START;
          tx_sh_d = bus_wdata[7:0];
          tx_d    = 1'b0;
        end
      end
      S_START: if (tx_cnt_q == CW'(DIV-1)) begin
        tx_cnt_d = '0;
        tx_bit_d = '0;
        tx_st_d  = S_DATA;
        tx_d     = tx_sh_q[0];
      end
      S_DATA: if (tx_cnt_q == CW'(DIV-1)) begin
        tx_cnt_d = '0;
        tx_sh_d  = tx_sh_q >> 1;
        if (tx_bit_q == 3'd7) begin
          tx_st_d = S_STOP;
          tx_d    = 1'b1;
        end else begin
          tx_bit_d = tx_bit_q + 1'b1;
          tx_d     = tx_sh_q[1];
        end
      end
      S_STOP: if (tx_cnt_q == CW'(DIV-1)) begin
        tx_cnt_d = '0;
        tx_st_d  = S_IDLE;
      end
      default: tx_st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      tx_st_q  <= S_IDLE;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q  <= '0;
      tx_q     <= 1'b1;
    end else begin
      tx_st_q  <= tx_st_d;
      tx_cnt_q <= tx_cnt_d;
      tx_bit_q <= tx_bit_d;
      tx_sh_q  <= tx_sh_d;
      tx_q     <= tx_d;
    end
  end

  // ---------------- RX ----------------
  logic           rx_s1_q, rx_s2_q, rx_prev_q;
  uart_st_e       rx_st_q, rx_st_d;
  logic [CW-1:0]  rx_cnt_q, rx_cnt_d;
  logic [2:0]     rx_bit_q, rx_bit_d;
  logic [7:0]     rx_sh_q, rx_sh_d, rx_byte_q, rx_byte_d;
  logic           rx_valid_q, rx_valid_d, overrun_q, overrun_d, ferr_q, ferr_d;
  logic           done_good, done_bad;

  always_comb begin
    rx_st_d   = rx_st_q;
    rx_cnt_d  = rx_cnt_q + 1'b1;
    rx_bit_d  = rx_bit_q;
    rx_sh_d   = rx_sh_q;
    done_good = 1'b0;
    done_bad  = 1'b0;
    case (rx_st_q)
      S_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_s2_q) rx_st_d = S_START;
      end
      S_START: if (rx_cnt_q == CW'(HALF-1)) begin
        rx_cnt_d = '0;
        rx_bit_d = '0;
        rx_st_d  = rx_s2_q ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_cnt_q == CW'(DIV-1)) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
        if (rx_bit_q == 3'd7) rx_st_d = S_STOP;
        else                  rx_bit_d = rx_bit_q + 1'b1;
      end
      S_STOP: if (rx_cnt_q == CW'(DIV-1)) begin
        rx_cnt_d  = '0;
        rx_st_d   = S_IDLE;
        done_good = rx_s2_q;
        done_bad  = ~rx_s2_q;
      end
      default: rx_st_d = S_IDLE;
    endcase

    rx_byte_d  = rx_byte_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    ferr_d     = ferr_q;
    // A completing byte beats a same-cycle DATA read.
    if (done_good) begin
      rx_byte_d  = rx_sh_q;
      rx_valid_d = 1'b1;
      overrun_d  = rx_valid_q & ~rd_data;
      ferr_d     = 1'b0;
    end else begin
      if (rd_data) begin
        rx_valid_d = 1'b0;
        overrun_d  = 1'b0;
      end
      if (done_bad) ferr_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_st_q    <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rx_s1_q    <= PICO_UART1_RX;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_st_q    <= rx_st_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
      ferr_q     <= ferr_d;
    end
  end

  // ---------------- read return ----------------
  logic        rd_ram_q;
  logic [31:0] per_rd_q, per_rd_d;

  always_comb begin
    per_rd_d = 32'h0;
    if (bus_rd && sel_data) per_rd_d = {24'h0, rx_byte_q};
    if (bus_rd && sel_stat) per_rd_d = {28'h0, ferr_q, overrun_q, rx_valid_q, tx_busy};
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rd_ram_q    <= 1'b0;
      per_rd_q    <= '0;
      mem_ready_q <= 1'b0;
    end else begin
      rd_ram_q    <= bus_rd & sel_ram;
      per_rd_q    <= per_rd_d;
      mem_ready_q <= cpu_n_reset & mem_valid & ~mem_ready_q;
    end
  end

  assign bus_rdata = rd_ram_q ? ram_rd_q : per_rd_q;
  assign dbg_di    = bus_rdata;
  assign mem_rdata = bus_rdata;
  assign mem_ready = mem_ready_q;
endmodule

// File: tb/tb_crv32_soc.sv
// Directed bench for crv32_soc: drives the debug master with the CPU held in reset.
module tb_crv32_soc;
  localparam int BIT = 104;
  localparam logic [31:0] A_DATA = 32'h0001_0010;
  localparam logic [31:0] A_STAT = 32'h0001_0014;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic txw;
  always #5 clk = ~clk;

  crv32_soc dut (.CLK(clk), .RESET(rst_n), .PICO_UART1_RX(rx), .PICO_UART1_TX(txw));

  logic        tb_op = 1'b0;
  logic [3:0]  tb_wren = 4'h0;
  logic [31:0] tb_adr = 32'h0, tb_do = 32'h0;

  int tests = 0, fails = 0, tx_falls = 0;
  always @(negedge txw) tx_falls = tx_falls + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int n);
    @(negedge clk);
    tb_adr = a; tb_do = d; tb_wren = s; tb_op = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk);
    tb_op = 1'b0; tb_wren = 4'h0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    tb_adr = a; tb_wren = 4'h0; tb_op = 1'b1;
    @(posedge clk);
    #1 d = dut.dbg_di;
    @(negedge clk);
    tb_op = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop;
    repeat (BIT) @(negedge clk);
    rx = 1'b1;
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  pat;
    int          falls0;
    force dut.cpu_n_reset = 1'b0;
    force dut.dbg_mem_op  = tb_op;
    force dut.dbg_wren    = tb_wren;
    force dut.dbg_adr     = tb_adr;
    force dut.dbg_do      = tb_do;

    // reset
    repeat (4) @(negedge clk);
    chk("tx_in_reset", {31'b0, txw}, 32'h1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("tx_after_reset", {31'b0, txw}, 32'h1);
    bus_rd(A_STAT, d); chk("stat_reset", d, 32'h0);
    bus_rd(A_DATA, d); chk("data_reset", d, 32'h0);

    // TX 0x11, write held 12 cycles
    pat = 8'h11;
    falls0 = tx_falls;
    bus_wr(A_DATA, 32'h11, 4'h1, 12);
    repeat (40) @(posedge clk);
    #1 chk("tx_start", {31'b0, txw}, 32'h0);
    bus_rd(A_STAT, d); chk("busy_start", d, 32'h1);
    for (int k = 0; k < 8; k++) begin
      repeat (BIT-1) @(posedge clk);
      #1 chk($sformatf("tx_bit%0d", k), {31'b0, txw}, {31'b0, pat[k]});
      bus_rd(A_STAT, d); chk($sformatf("busy_bit%0d", k), d, 32'h1);
    end
    repeat (BIT-1) @(posedge clk);
    #1 chk("tx_stop", {31'b0, txw}, 32'h1);
    bus_rd(A_STAT, d); chk("busy_stop", d, 32'h1);
    repeat (60) @(posedge clk);
    bus_rd(A_STAT, d); chk("busy_done", d, 32'h0);
    repeat (300) @(posedge clk);
    chk("one_frame_falls", 32'(tx_falls - falls0), 32'd3);
    chk("tx_idle_after", {31'b0, txw}, 32'h1);

    // RX single byte
    send(8'h88, 1'b1);
    bus_rd(A_STAT, d); chk("rx_stat_valid", d, 32'h2);
    bus_rd(A_DATA, d); chk("rx_data_88", d, 32'h88);
    bus_rd(A_STAT, d); chk("rx_stat_clear", d, 32'h0);

    // overrun
    send(8'h55, 1'b1);
    send(8'hAA, 1'b1);
    bus_rd(A_STAT, d); chk("ovr_stat", d, 32'h6);
    bus_rd(A_DATA, d); chk("ovr_data", d, 32'hAA);
    bus_rd(A_STAT, d); chk("ovr_clear", d, 32'h0);
    bus_rd(A_DATA, d); chk("data_kept", d, 32'hAA);

    // framing error, then recovery by a good byte
    send(8'h33, 1'b0);
    repeat (10) @(posedge clk);
    bus_rd(A_STAT, d); chk("ferr_stat", d, 32'h8);
    send(8'h5A, 1'b1);
    bus_rd(A_STAT, d); chk("ferr_cleared", d, 32'h2);
    bus_rd(A_DATA, d); chk("ferr_next_data", d, 32'h5A);

    // start-bit glitch is rejected
    @(negedge clk); rx = 1'b0;
    repeat (10) @(negedge clk); rx = 1'b1;
    repeat (1200) @(posedge clk);
    bus_rd(A_STAT, d); chk("glitch_stat", d, 32'h0);

    // RAM
    bus_wr(32'h40, 32'hDEADBEEF, 4'hF, 1);
    bus_wr(32'h40, 32'h00000012, 4'h1, 1);
    bus_rd(32'h40, d); chk("ram_byte0", d, 32'hDEADBE12);
    bus_wr(32'h44, 32'h11223344, 4'hF, 1);
    bus_wr(32'h44, 32'hAABBCCDD, 4'hA, 1);
    bus_rd(32'h44, d); chk("ram_strobe_a", d, 32'hAA22CC44);
    bus_wr(32'h0, 32'hCAFEF00D, 4'hF, 1);
    bus_wr(32'h1000, 32'h0BADBEEF, 4'hF, 1);
    bus_rd(32'h0, d); chk("ram_no_alias", d, 32'hCAFEF00D);
    bus_rd(32'h1000, d); chk("unmapped_rd", d, 32'h0);
    bus_rd(32'h0001_0018, d); chk("unmapped_uart", d, 32'h0);
    bus_rd(32'h40, d); chk("ram_readback2", d, 32'hDEADBE12);

    // reset mid-frame aborts TX at once
    bus_wr(A_DATA, 32'hA5, 4'h1, 1);
    repeat (30) @(posedge clk);
    #1 chk("abort_pre_tx", {31'b0, txw}, 32'h0);
    #2 rst_n = 1'b0;
    #1 chk("abort_tx_high", {31'b0, txw}, 32'h1);
    @(negedge clk); rst_n = 1'b1;
    bus_rd(A_STAT, d); chk("abort_stat", d, 32'h0);
    bus_rd(32'h44, d); chk("ram_survives_reset", d, 32'hAA22CC44);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
